// File: rtl/alu_pkg.sv
// alu_pkg: shared types and default widths for the ALU result/writeback stage.
//   DATAW_DEF  - default data width (ALU alu_out)
//   REGW_DEF   - default destination register index width
//   wb_entry_t - one buffered result: data, rd, wen, pwen, pflag
package alu_pkg;

    localparam int unsigned DATAW_DEF = 32;
    localparam int unsigned REGW_DEF  = 5;

    typedef struct packed {
        logic [DATAW_DEF-1:0] data;
        logic [REGW_DEF-1:0]  rd;
        logic                 wen;
        logic                 pwen;
        logic                 pflag;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: in-order valid/ready buffer of wb_entry_t.
// Build option ALU_WB_SKID_EN:
//   defined   - 2-entry skid buffer, push_ready registered (no path from pop_ready)
//   undefined - 1-entry pipeline register, push_ready combinational from pop_ready
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   flush            - drop all entries; overrides push and pop
//   push_valid/ready - enqueue handshake, push_entry is the new tail
//   pop_valid/ready  - dequeue handshake, pop_entry is the head
//   occupancy        - number of buffered entries
module wb_skid_buf
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push_valid,
    output logic       push_ready,
    input  wb_entry_t  push_entry,
    output logic       pop_valid,
    input  logic       pop_ready,
    output wb_entry_t  pop_entry,
    output logic [1:0] occupancy
);

`ifdef ALU_WB_SKID_EN

    wb_entry_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic       rdy_q;
    logic       push;
    logic       pop;

    assign push = push_valid && rdy_q && !flush;
    assign pop  = pop_ready && (occ_q != 2'd0) && !flush;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            rdy_q    <= 1'b0;
        end else begin
            occ_q <= occ_d;
            // Ready for next cycle is decided from the post-update occupancy only.
            rdy_q <= (occ_d != 2'd2);
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Payload needs no reset; it is only observed while valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign push_ready = rdy_q && !rst;
    assign pop_valid  = (occ_q != 2'd0);
    assign pop_entry  = mem_q[rd_ptr_q];
    assign occupancy  = occ_q;

`else

    wb_entry_t ent_q;
    logic      valid_q;
    logic      push;
    logic      pop;

    // Combinational path from pop_ready lets a full stage accept while retiring.
    assign push_ready = !rst && (!valid_q || pop_ready);
    assign push       = push_valid && push_ready && !flush;
    assign pop        = valid_q && pop_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (push) begin
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) ent_q <= push_entry;
    end

    assign pop_valid = valid_q;
    assign pop_entry = ent_q;
    assign occupancy = {1'b0, valid_q};

`endif

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: result/writeback stage behind the ALU. Buffers results in order and
// retires one per cycle to the register-file write port; owns predicate register p_reg.
// Build option ALU_WB_SKID_EN selects the 2-entry skid buffer (see wb_skid_buf).
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   flush         - discard all non-retired entries (beats accept and retire)
//   in_*          - ALU result handshake: data, pflag, rd, wen, pwen
//   out_*         - head entry to register file: valid/ready, data, rd, wen (zero if !valid)
//   p_reg         - architectural predicate, written when a pwen entry retires
//   occupancy     - buffered entry count
// DATAW/REGW must match the alu_pkg defaults that size wb_entry_t.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATAW = DATAW_DEF,
    parameter int unsigned REGW  = REGW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_pflag,
    input  logic [REGW-1:0]  in_rd,
    input  logic             in_wen,
    input  logic             in_pwen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic [REGW-1:0]  out_rd,
    output logic             out_wen,
    output logic             p_reg,
    output logic [1:0]       occupancy
);

    wb_entry_t  in_entry;
    wb_entry_t  head;
    logic       head_valid;
    logic [1:0] buf_occ;
    logic       retire;
    logic       p_reg_q;

    assign in_entry = '{data: in_data, rd: in_rd, wen: in_wen, pwen: in_pwen, pflag: in_pflag};

    wb_skid_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_entry (in_entry),
        .pop_valid  (head_valid),
        .pop_ready  (out_ready),
        .pop_entry  (head),
        .occupancy  (buf_occ)
    );

    // A flush cycle retires nothing, so p_reg cannot move under a flush.
    assign retire = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg_q <= 1'b0;
        end else if (retire && head.pwen) begin
            p_reg_q <= head.pflag;
        end
    end

    // Outputs read as idle while rst is high, even before the reset edge lands.
    assign out_valid = head_valid && !rst;
    assign out_data  = out_valid ? head.data : '0;
    assign out_rd    = out_valid ? head.rd : '0;
    assign out_wen   = out_valid && head.wen;
    assign p_reg     = p_reg_q && !rst;
    assign occupancy = rst ? 2'd0 : buf_occ;

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: scoreboard bench for alu_wb_stage. A negedge monitor checks the DUT
// state against a reference queue, then advances that queue for the coming edge.
module tb_alu_wb_stage;

`ifdef ALU_WB_SKID_EN
    localparam int CAP = 2;
    localparam bit SKID = 1'b1;
`else
    localparam int CAP = 1;
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_pflag = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_wen = 1'b0;
    logic        in_pwen = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        p_reg;
    logic [1:0]  occupancy;

    alu_wb_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pflag  (in_pflag),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .in_pwen   (in_pwen),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_wen   (out_wen),
        .p_reg     (p_reg),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        wen;
        logic        pwen;
        logic        pf;
    } exp_t;

    exp_t q[$];
    logic p_m   = 1'b0;
    logic rdy_m = 1'b0;
    bit   mon_en = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: compare current state, then apply this cycle's handshakes.
    logic rdy_e;
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            rdy_e = SKID ? rdy_m : (q.size() == 0 || out_ready);
            if (rst) begin
                check_val("rst_in_ready", {31'b0, in_ready}, 32'd0);
                check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
                check_val("rst_occ", {30'b0, occupancy}, 32'd0);
                check_val("rst_p_reg", {31'b0, p_reg}, 32'd0);
                check_val("rst_out_data", out_data, 32'd0);
            end else begin
                check_val("in_ready", {31'b0, in_ready}, {31'b0, rdy_e});
                check_val("occupancy", {30'b0, occupancy}, 32'(q.size()));
                check_val("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
                check_val("p_reg", {31'b0, p_reg}, {31'b0, p_m});
                if (q.size() != 0) begin
                    check_val("out_data", out_data, q[0].d);
                    check_val("out_rd", {27'b0, out_rd}, {27'b0, q[0].rd});
                    check_val("out_wen", {31'b0, out_wen}, {31'b0, q[0].wen});
                end else begin
                    check_val("idle_data", out_data, 32'd0);
                    check_val("idle_rd", {27'b0, out_rd}, 32'd0);
                    check_val("idle_wen", {31'b0, out_wen}, 32'd0);
                end
            end
            if (rst) begin
                q.delete();
                p_m   = 1'b0;
                rdy_m = 1'b0;
            end else if (flush) begin
                q.delete();
                rdy_m = 1'b1;
            end else begin
                if (out_ready && q.size() != 0) begin
                    e = q.pop_front();
                    if (e.pwen) p_m = e.pf;
                end
                if (in_valid && rdy_e) begin
                    q.push_back('{d: in_data, rd: in_rd, wen: in_wen, pwen: in_pwen,
                                  pf: in_pflag});
                end
                rdy_m = (q.size() < 2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry and hold it until accepted, bounded to 20 cycles.
    task automatic send(input logic [31:0] d, input logic [4:0] rd, input logic w,
                        input logic pw, input logic pf);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_rd    = rd;
        in_wen   = w;
        in_pwen  = pw;
        in_pflag = pf;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (in_ready) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        if (!done) check_val("send_timeout", 32'd0, 32'd1);
    endtask

    int c0;

    initial begin
        // Reset with in_valid held high: nothing may be taken.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step();
        step();
        check_val("rst_hold_rdy", {31'b0, in_ready}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check_val("post_rst_valid", {31'b0, out_valid}, 32'd0);

        // Single pass.
        out_ready = 1'b1;
        send(32'h5, 5'd3, 1'b1, 1'b1, 1'b1);
        check_val("sp_valid", {31'b0, out_valid}, 32'd1);
        check_val("sp_data", out_data, 32'h5);
        check_val("sp_rd", {27'b0, out_rd}, 32'd3);
        step();
        check_val("sp_p_reg", {31'b0, p_reg}, 32'd1);

        // Backpressure: A, B, C offered while the consumer stalls.
        out_ready = 1'b0;
        fork
            begin
                send(32'hA, 5'd1, 1'b1, 1'b0, 1'b0);
                send(32'hB, 5'd2, 1'b0, 1'b0, 1'b0);
                send(32'hC, 5'd4, 1'b1, 1'b0, 1'b0);
            end
            begin
                repeat (5) step();
                check_val("bp_occ", {30'b0, occupancy}, 32'(CAP));
                check_val("bp_ready", {31'b0, in_ready}, 32'd0);
                out_ready = 1'b1;
            end
        join
        repeat (3) step();

        // Predicate isolation.
        send(32'h10, 5'd5, 1'b1, 1'b1, 1'b1);
        send(32'h11, 5'd6, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        check_val("p_iso", {31'b0, p_reg}, 32'd1);

        // Flush while full with a pending input and a ready consumer.
        out_ready = 1'b0;
        send(32'h21, 5'd7, 1'b1, 1'b1, 1'b0);
        if (CAP == 2) send(32'h22, 5'd8, 1'b1, 1'b1, 1'b0);
        in_valid  = 1'b1;
        in_data   = 32'h33;
        in_pwen   = 1'b1;
        in_pflag  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("fl_occ", {30'b0, occupancy}, 32'd0);
        check_val("fl_valid", {31'b0, out_valid}, 32'd0);
        check_val("fl_p_reg", {31'b0, p_reg}, 32'd1);
        step();
        check_val("fl_dropped", {31'b0, out_valid}, 32'd0);

        // Reset mid-operation.
        out_ready = 1'b0;
        send(32'h44, 5'd9, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mr_occ", {30'b0, occupancy}, 32'd0);
        check_val("mr_p_reg", {31'b0, p_reg}, 32'd0);
        step();

        // Streaming: one accept per cycle with the consumer always ready.
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            send($urandom, 5'($urandom_range(31)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        check_val("throughput", 32'(cyc - c0), 32'd6);

        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        check_val("drain", 32'(q.size()), 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
